// File: rtl/tx_beam_ch.sv
// Per-channel transmit beamformer.
// A shared fire strobe starts a shot: the channel reads its focal delay for the
// selected line from a local LUT, waits that many clocks, then emits a bipolar
// pulser burst of programmable half-period and cycle count. Timing is identical
// whether or not the channel is apodised on, so done stays aligned across channels.
module tx_beam_ch #(
    parameter int unsigned ADDR_WD  = 7,
    parameter int unsigned DELAY_WD = 12,
    parameter int unsigned HALF_WD  = 8,
    parameter int unsigned NCYC_WD  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_WD-1:0]  lut_addr,
    input  logic                lut_we,
    input  logic [DELAY_WD-1:0] lut_din,
    input  logic                cfg_we,
    input  logic [HALF_WD-1:0]  cfg_half_period,
    input  logic [NCYC_WD-1:0]  cfg_num_cycles,
    input  logic                cfg_enable,
    input  logic [ADDR_WD-1:0]  line_sel,
    input  logic                fire,
    input  logic                abort,
    output logic                pulse_p,
    output logic                pulse_n,
    output logic                tx_active,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WD;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // ------------------------------------------------------------------
    // Delay LUT
    // ------------------------------------------------------------------
    logic [DELAY_WD-1:0] mem_q [DEPTH];
    logic [DELAY_WD-1:0] rdata_q;
    logic                rd_en_c;

    logic [2:0]          state_q, state_d;

    // The read is launched in the IDLE cycle that accepts fire, so the
    // delay is already registered when FETCH begins; this also latches line_sel.
    assign rd_en_c = (state_q == S_IDLE) && fire && !abort;

    // Write port and registered read-first read port; contents are not reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            mem_q[lut_addr] <= lut_din;
        end
        if (rd_en_c) begin
            rdata_q <= mem_q[line_sel];
        end
    end

    // ------------------------------------------------------------------
    // Config registers (host side)
    // ------------------------------------------------------------------
    logic [HALF_WD-1:0] cfg_half_q;
    logic [NCYC_WD-1:0] cfg_ncyc_q;
    logic               cfg_en_q;

    // Host-loaded configuration, shadowed into the working set on fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_half_q <= HALF_WD'(1);
            cfg_ncyc_q <= NCYC_WD'(1);
            cfg_en_q   <= 1'b0;
        end else if (cfg_we) begin
            cfg_half_q <= cfg_half_period;
            cfg_ncyc_q <= cfg_num_cycles;
            cfg_en_q   <= cfg_enable;
        end
    end

    // ------------------------------------------------------------------
    // Shot sequencer
    // ------------------------------------------------------------------
    logic [HALF_WD-1:0]  wrk_half_q,  wrk_half_d;
    logic [NCYC_WD-1:0]  wrk_ncyc_q,  wrk_ncyc_d;
    logic                wrk_en_q,    wrk_en_d;
    logic [DELAY_WD-1:0] dly_cnt_q,   dly_cnt_d;
    logic [HALF_WD-1:0]  half_cnt_q,  half_cnt_d;
    logic [NCYC_WD-1:0]  cyc_cnt_q,   cyc_cnt_d;
    logic                phase_q,     phase_d;
    logic                pulse_p_q,   pulse_p_d;
    logic                pulse_n_q,   pulse_n_d;
    logic                tx_active_q, tx_active_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // State, working config, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wrk_half_q  <= HALF_WD'(1);
            wrk_ncyc_q  <= NCYC_WD'(1);
            wrk_en_q    <= 1'b0;
            dly_cnt_q   <= '0;
            half_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
            phase_q     <= 1'b0;
            pulse_p_q   <= 1'b0;
            pulse_n_q   <= 1'b0;
            tx_active_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrk_half_q  <= wrk_half_d;
            wrk_ncyc_q  <= wrk_ncyc_d;
            wrk_en_q    <= wrk_en_d;
            dly_cnt_q   <= dly_cnt_d;
            half_cnt_q  <= half_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            phase_q     <= phase_d;
            pulse_p_q   <= pulse_p_d;
            pulse_n_q   <= pulse_n_d;
            tx_active_q <= tx_active_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that the
    // output flops line up exactly with the state they describe.
    always_comb begin
        state_d     = state_q;
        wrk_half_d  = wrk_half_q;
        wrk_ncyc_d  = wrk_ncyc_q;
        wrk_en_d    = wrk_en_q;
        dly_cnt_d   = dly_cnt_q;
        half_cnt_d  = half_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d    = S_FETCH;
                    wrk_half_d = (cfg_half_q == '0) ? HALF_WD'(1) : cfg_half_q;
                    wrk_ncyc_d = cfg_ncyc_q;
                    wrk_en_d   = cfg_en_q;
                end
            end

            S_FETCH: begin
                dly_cnt_d = rdata_q;
                if (rdata_q != '0) begin
                    state_d = S_DELAY;
                end else if (wrk_ncyc_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_PULSE;
                    half_cnt_d = wrk_half_q;
                    cyc_cnt_d  = wrk_ncyc_q;
                    phase_d    = 1'b0;
                end
            end

            S_DELAY: begin
                if (dly_cnt_q == DELAY_WD'(1)) begin
                    if (wrk_ncyc_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_PULSE;
                        half_cnt_d = wrk_half_q;
                        cyc_cnt_d  = wrk_ncyc_q;
                        phase_d    = 1'b0;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q - DELAY_WD'(1);
                end
            end

            S_PULSE: begin
                // Nested counting: half-period inside phase inside cycle.
                if (half_cnt_q == HALF_WD'(1)) begin
                    half_cnt_d = wrk_half_q;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (cyc_cnt_q == NCYC_WD'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d   = 1'b0;
                        cyc_cnt_d = cyc_cnt_q - NCYC_WD'(1);
                    end
                end else begin
                    half_cnt_d = half_cnt_q - HALF_WD'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end

        pulse_p_d   = wrk_en_d && (state_d == S_PULSE) && !phase_d;
        pulse_n_d   = wrk_en_d && (state_d == S_PULSE) &&  phase_d;
        tx_active_d = (state_d == S_DELAY) || (state_d == S_PULSE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    assign pulse_p   = pulse_p_q;
    assign pulse_n   = pulse_n_q;
    assign tx_active = tx_active_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tx_beam_ch.sv
// Self-checking bench for tx_beam_ch: directed shots from the test plan plus
// randomised shots, checked cycle by cycle against a timeline model.
module tb_tx_beam_ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  lut_addr;
    logic        lut_we;
    logic [11:0] lut_din;
    logic        cfg_we;
    logic [7:0]  cfg_half_period;
    logic [3:0]  cfg_num_cycles;
    logic        cfg_enable;
    logic [6:0]  line_sel;
    logic        fire;
    logic        abort;
    logic        pulse_p;
    logic        pulse_n;
    logic        tx_active;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: LUT contents and host config as the bench believes them.
    int m_lut [128];
    int m_half;
    int m_ncyc;
    int m_en;

    tx_beam_ch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lut_addr        (lut_addr),
        .lut_we          (lut_we),
        .lut_din         (lut_din),
        .cfg_we          (cfg_we),
        .cfg_half_period (cfg_half_period),
        .cfg_num_cycles  (cfg_num_cycles),
        .cfg_enable      (cfg_enable),
        .line_sel        (line_sel),
        .fire            (fire),
        .abort           (abort),
        .pulse_p         (pulse_p),
        .pulse_n         (pulse_n),
        .tx_active       (tx_active),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] obs_vec();
        return {pulse_p, pulse_n, tx_active, busy, done};
    endfunction

    // Expected {pulse_p,pulse_n,tx_active,busy,done} at cycle t after fire (t=0).
    function automatic logic [4:0] model(int t, int d, int h, int n, int en);
        int   ps, pe, td;
        logic p, q;
        ps = 2 + d;
        pe = 1 + d + 2 * h * n;
        td = 2 + d + 2 * h * n;
        p  = 1'b0;
        q  = 1'b0;
        if (t >= ps && t <= pe) begin
            if ((((t - ps) / h) % 2) == 0) p = (en != 0);
            else                          q = (en != 0);
        end
        return {p, q, (t >= 2 && t <= pe), (t >= 1 && t <= td), (t == td)};
    endfunction

    task automatic chk(input string tag, input int t, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed{p,n,tx,busy,done}=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int n, input int en);
        cfg_half_period = 8'(h);
        cfg_num_cycles  = 4'(n);
        cfg_enable      = 1'(en);
        cfg_we          = 1'b1;
        tick();
        cfg_we = 1'b0;
        m_half = h;
        m_ncyc = n;
        m_en   = en;
        chk("cfg_idle", 0, obs_vec(), 5'b0);
    endtask

    task automatic lut_write(input int line, input int val);
        lut_addr = 7'(line);
        lut_din  = 12'(val);
        lut_we   = 1'b1;
        tick();
        lut_we = 1'b0;
        m_lut[line] = val;
    endtask

    // One shot fired in the current cycle; optional side events at given cycles
    // (negative = unused). Ends in the first cycle a new fire is accepted,
    // or right after an abort/reset.
    task automatic run_shot(input string tag, input int line, input int abort_at,
                            input int xfire_at, input int cfg_at, input int cfg_n,
                            input int lut_at, input int lut_val, input int rst_at);
        int d, h, n, en, t_end;
        logic [4:0] exp;
        d     = m_lut[line];
        h     = (m_half == 0) ? 1 : m_half;
        n     = m_ncyc;
        en    = m_en;
        t_end = 3 + d + 2 * h * n;
        line_sel = 7'(line);
        fire     = 1'b1;
        for (int t = 1; t <= t_end; t++) begin
            tick();
            fire   = 1'b0;
            abort  = 1'b0;
            lut_we = 1'b0;
            cfg_we = 1'b0;
            exp = (abort_at >= 0 && t > abort_at) ? 5'b0 : model(t, d, h, n, en);
            chk(tag, t, obs_vec(), exp);
            if (abort_at >= 0 && t > abort_at) break;
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_async"}, t, obs_vec(), 5'b0);
                m_half = 1;
                m_ncyc = 1;
                m_en   = 0;
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                chk({tag, "_after"}, t + 1, obs_vec(), 5'b0);
                break;
            end
            if (t == abort_at) abort = 1'b1;
            if (t == xfire_at) begin
                fire     = 1'b1;
                line_sel = 7'($urandom_range(127));
            end
            if (t == cfg_at) begin
                cfg_num_cycles = 4'(cfg_n);
                cfg_we         = 1'b1;
                m_ncyc         = cfg_n;
            end
            if (t == lut_at) begin
                lut_addr    = 7'(line);
                lut_din     = 12'(lut_val);
                lut_we      = 1'b1;
                m_lut[line] = lut_val;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lut_addr = '0; lut_we = 1'b0; lut_din = '0;
        cfg_we = 1'b0; cfg_half_period = '0; cfg_num_cycles = '0; cfg_enable = 1'b0;
        line_sel = '0; fire = 1'b0; abort = 1'b0;
        m_half = 1; m_ncyc = 1; m_en = 0;
        for (int i = 0; i < 128; i++) m_lut[i] = 0;

        // Reset state
        #12;
        chk("reset", 0, obs_vec(), 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset", 0, obs_vec(), 5'b0);

        lut_write(3, 5);
        lut_write(0, 0);

        // Reset config (H=1, N=1, enable=0) on a zero-delay line
        run_shot("reset_cfg", 0, -1, -1, -1, 0, -1, 0, -1);

        // Basic shot
        set_cfg(2, 2, 1);
        run_shot("basic", 3, -1, -1, -1, 0, -1, 0, -1);
        // Back-to-back shot fired in the first idle cycle
        run_shot("back2back", 3, -1, -1, -1, 0, -1, 0, -1);

        // Zero delay, zero half-period
        set_cfg(0, 1, 1);
        run_shot("zero_dly_half", 0, -1, -1, -1, 0, -1, 0, -1);

        // Apodised off
        set_cfg(2, 2, 0);
        run_shot("apod_off", 3, -1, -1, -1, 0, -1, 0, -1);

        // N=0 skips the burst
        set_cfg(2, 0, 1);
        run_shot("ncyc0", 3, -1, -1, -1, 0, -1, 0, -1);
        run_shot("ncyc0_dly0", 0, -1, -1, -1, 0, -1, 0, -1);

        // Abort at 9, fresh fire at 10
        set_cfg(2, 2, 1);
        run_shot("abort", 3, 9, -1, -1, 0, -1, 0, -1);
        run_shot("after_abort", 3, -1, -1, -1, 0, -1, 0, -1);

        // Abort and fire together in IDLE: no shot
        fire  = 1'b1;
        abort = 1'b1;
        tick();
        fire  = 1'b0;
        abort = 1'b0;
        chk("abort_fire", 1, obs_vec(), 5'b0);
        tick();
        chk("abort_fire", 2, obs_vec(), 5'b0);

        // Ignored second fire and shadowed config write
        run_shot("shadow", 3, -1, 5, 6, 1, -1, 0, -1);
        run_shot("shadow_next", 3, -1, -1, -1, 0, -1, 0, -1);
        set_cfg(2, 2, 1);

        // LUT write in FETCH: current shot keeps old delay
        run_shot("collide", 3, -1, -1, -1, 0, 1, 9, -1);
        run_shot("collide_next", 3, -1, -1, -1, 0, -1, 0, -1);

        // Asynchronous reset mid-shot, then reset config reappears
        lut_write(3, 5);
        run_shot("mid_reset", 3, -1, -1, -1, 0, -1, 0, 8);
        run_shot("post_rst_cfg", 3, -1, -1, -1, 0, -1, 0, -1);

        // Randomised shots
        for (int i = 16; i < 32; i++) lut_write(i, int'($urandom_range(20)));
        for (int s = 0; s < 25; s++) begin
            set_cfg(int'($urandom_range(5)), int'($urandom_range(4)), int'($urandom_range(1)));
            run_shot("random", 16 + int'($urandom_range(15)), -1, -1, -1, 0, -1, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_beam_ch.md
# tx_beam_ch

Per-channel transmit beamformer: the transmit-side counterpart of the per-channel receive delay/apodisation path. On a common `fire` strobe, each channel looks up its focal transmit delay for the selected line in a local delay LUT. It waits that many clocks, then drives a bipolar pulser burst (`pulse_p`/`pulse_n`) with programmable half-period and cycle count. One instance per element. All instances share `fire`, `line_sel` and the config bus, and are loaded individually through their LUT port.

## Interface
- `ADDR_WD`, 7: delay LUT address width (depth 2^ADDR_WD lines).
- `DELAY_WD`, 12: transmit delay width, in clocks.
- `HALF_WD`, 8: pulse half-period width, in clocks.
- `NCYC_WD`, 4: burst cycle-count width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lut_addr`  in  ADDR_WD  delay LUT write address.
- `lut_we`  in  1  delay LUT write enable.
- `lut_din`  in  DELAY_WD  delay value to write.
- `cfg_we`  in  1  load the `cfg_*` inputs into the config registers.
- `cfg_half_period`  in  HALF_WD  clocks per half pulse; 0 is treated as 1.
- `cfg_num_cycles`  in  NCYC_WD  number of bipolar cycles in the burst.
- `cfg_enable`  in  1  transmit apodisation: 0 keeps the outputs silent.
- `line_sel`  in  ADDR_WD  LUT line to use; sampled on `fire`.
- `fire`  in  1  start of shot; level sampled in IDLE.
- `abort`  in  1  synchronous abort; has priority over everything.
- `pulse_p`  out  1  positive pulser drive.
- `pulse_n`  out  1  negative pulser drive.
- `tx_active`  out  1  high in DELAY and PULSE.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle end-of-shot strobe.

## Operation
- **Delay LUT.** Simple dual-port RAM, depth 2^ADDR_WD. Writes are synchronous when `lut_we`=1, at any time. Read is registered and read-first: a same-cycle write to the address being read returns the old data. Contents are not reset.
- **Config registers.** Loaded on `cfg_we`. On `fire` they are copied into working registers, so a config write during a shot takes effect at the next shot.
- **FSM states:** IDLE, FETCH, DELAY, PULSE, DONE.
  - IDLE: `fire`=1 and `abort`=0 → latch `line_sel` and the working config, go to FETCH.
  - FETCH: one cycle of RAM read. The delay counter is loaded with d = LUT[line]. Go to DELAY if d>0, else PULSE.
  - DELAY: the counter decrements once per cycle. After d cycles, go to PULSE.
  - PULSE: lasts 2·H·N cycles, where H = max(half_period,1) and N = num_cycles. Each bipolar cycle is H cycles of `pulse_p`=1 followed by H cycles of `pulse_n`=1. With N=0, PULSE is skipped: DELAY/FETCH goes straight to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- With enable=0, the FSM timing is identical (so `done` stays aligned across channels) but `pulse_p`/`pulse_n` stay 0.
- `pulse_p` and `pulse_n` are never high together. Both are direct flop outputs, so there is no glitching.
- `fire` is ignored outside IDLE. Only the first shot runs; there is no queueing.
- `abort`=1 in any state → IDLE at the next edge. From that edge all outputs are 0 and no `done` is issued. When `abort` and `fire` coincide in IDLE, `abort` wins and the shot does not start.

## Timing
- Reset values:
  - `pulse_p`, `pulse_n`, `tx_active`, `busy`, `done` = 0; state = IDLE.
  - Config: half_period=1, num_cycles=1, enable=0.
- Reset asserted mid-shot forces the reset values asynchronously; the shot is lost.
- With `fire` sampled high in cycle k:
  - `busy`=1 from k+1.
  - FETCH in k+1.
  - DELAY in k+2 … k+1+d.
  - First `pulse_p` in k+2+d.
  - PULSE ends in k+1+d+2HN.
  - `done` in k+2+d+2HN.
  - `busy`=0 in k+3+d+2HN, which is also the earliest cycle a new `fire` is accepted.
- `tx_active` follows the DELAY/PULSE states exactly.
- Width rules:
  - Delay counter is DELAY_WD bits.
  - Half-period counter is HALF_WD bits.
  - Cycle counter is NCYC_WD bits.
  - No overflow is possible: the maximum burst is 2·255·15 clocks, counted as nested counters, not a product.

## Test plan
- Basic shot: LUT[3]=5, H=2, N=2, enable=1, `fire` with line 3 at cycle 0 → `pulse_p` in cycles 7–8 and 11–12, `pulse_n` in 9–10 and 13–14, `done` at 15, `busy` in 1–15.
- Zero delay and half-period: LUT[0]=0, H=0 (treated as 1), N=1 → `pulse_p` at 2, `pulse_n` at 3, `done` at 4.
- Apodised off: basic-shot config with enable=0 → `pulse_p`/`pulse_n` low throughout, `tx_active` in 2–14, `done` at 15.
- Abort: basic-shot config, `abort` high in cycle 9 → both outputs 0 and `busy` 0 from cycle 10, no `done`. A new `fire` at 10 starts a fresh shot with `pulse_p` at 17.
- Ignore and shadow: a second `fire` at cycle 5 is ignored. `cfg_we` writing N=1 at cycle 6 leaves the current burst at 8 pulse cycles; the next shot has 4.
- Reset and RAM collision: `rst_n` low at cycle 8 → all outputs 0 immediately. Separately, a LUT write to line 3 (value 9) in the FETCH cycle → the current shot uses the old delay 5, the next shot uses 9.
